// File: rtl/alu_uart_interface.sv
// Sequencing stage between the UART and the combinational ALU: gathers operand A,
// operand B and opcode bytes, captures the 9-bit result and returns it as two bytes.
module alu_uart_interface #(
    parameter int OPERAND_SIZE = 8,
    parameter int OP_CODE_SIZE = 6
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_rx_done,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_tx_done,
    output logic                    o_tx_start,
    output logic [7:0]              o_tx_data,
    output logic [OPERAND_SIZE-1:0] o_dato_a,
    output logic [OPERAND_SIZE-1:0] o_dato_b,
    output logic [OP_CODE_SIZE-1:0] o_op_code,
    input  logic [OPERAND_SIZE:0]   i_resultado,
    output logic                    o_busy
);

    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI
    } state_t;

    state_t state, state_next;
    logic   ld_a, ld_b, ld_op, ld_res, send_lo, send_hi;
    logic [OPERAND_SIZE:0] result;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= WAIT_A;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_A:  if (i_rx_done) state_next = WAIT_B;
            WAIT_B:  if (i_rx_done) state_next = WAIT_OP;
            WAIT_OP: if (i_rx_done) state_next = COMPUTE;
            COMPUTE: state_next = SEND_LO;
            SEND_LO: state_next = WAIT_LO;
            WAIT_LO: if (i_tx_done) state_next = SEND_HI;
            SEND_HI: state_next = WAIT_HI;
            WAIT_HI: if (i_tx_done) state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    always_comb begin
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_op   = 1'b0;
        ld_res  = 1'b0;
        send_lo = 1'b0;
        send_hi = 1'b0;
        o_busy  = 1'b1;
        case (state)
            WAIT_A:  begin ld_a  = i_rx_done; o_busy = 1'b0; end
            WAIT_B:  begin ld_b  = i_rx_done; o_busy = 1'b0; end
            WAIT_OP: begin ld_op = i_rx_done; o_busy = 1'b0; end
            COMPUTE: ld_res  = 1'b1;
            SEND_LO: send_lo = 1'b1;
            SEND_HI: send_hi = 1'b1;
            default: ;
        endcase
    end

    // Send strobes are registered, so the start pulse appears in the cycle after SEND_*.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_dato_a   <= '0;
            o_dato_b   <= '0;
            o_op_code  <= '0;
            result     <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            o_tx_start <= send_lo | send_hi;
            if (ld_a)    o_dato_a  <= i_rx_data[OPERAND_SIZE-1:0];
            if (ld_b)    o_dato_b  <= i_rx_data[OPERAND_SIZE-1:0];
            if (ld_op)   o_op_code <= i_rx_data[OP_CODE_SIZE-1:0];
            if (ld_res)  result    <= i_resultado;
            if (send_lo) o_tx_data <= result[7:0];
            if (send_hi) o_tx_data <= {7'b0, result[OPERAND_SIZE]};
        end
    end

endmodule
